// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port front end for the single-port data memory.
// Port 0 = core LSU, port 1 = DMA/debug; one access in flight at a time.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   reqN/weN/addrN/...    request + access fields of port N (0/1)
//   gntN/doneN/errN       grant, completion and reject pulses to port N
//   rdata                 last completed load result
//   mem_*                 drive/return of the registered-read memory
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_BYTES  = 32'h0010_0000,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [1:0]            wsel0,
  input  logic [2:0]            rsel0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [1:0]            wsel1,
  input  logic [2:0]            rsel1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  done0,
  output logic                  done1,
  output logic                  err0,
  output logic                  err1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dataw,
  output logic                  mem_memrw,
  output logic [1:0]            mem_wsel,
  output logic [2:0]            mem_rsel,
  input  logic [DATA_WIDTH-1:0] mem_datar
);

  localparam logic [DATA_WIDTH:0] ADDR_LIM =
    (DATA_WIDTH+1)'(MEM_BYTES);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RDWAIT
  } state_t;

  state_t                state_q, state_d;
  logic                  rr_q, rr_d;
  logic                  own_q, own_d;
  logic                  errp_q, errp_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [1:0]            wsel_q, wsel_d;
  logic [2:0]            rsel_q, rsel_d;
  logic                  gnt0_q, gnt0_d;
  logic                  gnt1_q, gnt1_d;
  logic                  done0_q, done0_d;
  logic                  done1_q, done1_d;
  logic                  err0_q, err0_d;
  logic                  err1_q, err1_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  any_req;
  logic                  win;
  logic                  s_we;
  logic [DATA_WIDTH-1:0] s_addr;
  logic [DATA_WIDTH-1:0] s_wdata;
  logic [1:0]            s_wsel;
  logic [2:0]            s_rsel;
  logic                  bad_rsel;
  logic                  s_ill;

  assign any_req = req0 | req1;

  // Tie: pointer port (or port 0 when fixed); otherwise the lone requester.
  always_comb begin
    win = 1'b0;
    if (req0 && req1) begin
      win = FIXED_PRIO ? 1'b0 : rr_q;
    end else begin
      win = req1;
    end
  end

  assign s_we    = win ? we1    : we0;
  assign s_addr  = win ? addr1  : addr0;
  assign s_wdata = win ? wdata1 : wdata0;
  assign s_wsel  = win ? wsel1  : wsel0;
  assign s_rsel  = win ? rsel1  : rsel0;

  always_comb begin
    bad_rsel = 1'b0;
    unique case (s_rsel)
      3'b001, 3'b110, 3'b111: bad_rsel = 1'b1;
      default:                bad_rsel = 1'b0;
    endcase
  end

  assign s_ill = (s_addr[1:0] != 2'b00)
               | ({1'b0, s_addr} >= ADDR_LIM)
               | (s_we & (s_wsel == 2'b11))
               | (~s_we & bad_rsel);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    own_d   = own_q;
    errp_d  = 1'b0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wsel_d  = wsel_q;
    rsel_d  = rsel_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err0_d  = 1'b0;
    err1_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        // A rejected access spends its grant cycle here; the
        // owner still holds req then, so nothing is sampled.
        if (errp_q) begin
          done0_d = ~own_q;
          done1_d = own_q;
          err0_d  = ~own_q;
          err1_d  = own_q;
        end else if (any_req) begin
          own_d   = win;
          we_d    = s_we;
          addr_d  = s_addr;
          wdata_d = s_wdata;
          wsel_d  = s_wsel;
          rsel_d  = s_rsel;
          gnt0_d  = ~win;
          gnt1_d  = win;
          rr_d    = ~win;
          if (s_ill) begin
            errp_d = 1'b1;
          end else begin
            state_d = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = IDLE;
          done0_d = ~own_q;
          done1_d = own_q;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        rdata_d = mem_datar;
        state_d = IDLE;
        done0_d = ~own_q;
        done1_d = own_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      own_q   <= 1'b0;
      errp_q  <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wsel_q  <= '0;
      rsel_q  <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err0_q  <= 1'b0;
      err1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      own_q   <= own_d;
      errp_q  <= errp_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wsel_q  <= wsel_d;
      rsel_q  <= rsel_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err0_q  <= err0_d;
      err1_q  <= err1_d;
      rdata_q <= rdata_d;
    end
  end

  // Memory sees a live access only in ACCESS; reset drops it at once.
  always_comb begin
    mem_addr  = '0;
    mem_dataw = '0;
    mem_memrw = 1'b0;
    mem_wsel  = '0;
    mem_rsel  = '0;
    if (state_q == ACCESS) begin
      mem_addr  = addr_q;
      mem_dataw = wdata_q;
      mem_memrw = we_q;
      mem_wsel  = wsel_q;
      mem_rsel  = rsel_q;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign err0  = err0_q;
  assign err1  = err1_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a
// cycle-level transaction model and a registered-read memory.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0;
  logic [31:0] wdata0 = '0, wdata1 = '0;
  logic [1:0]  wsel0 = '0, wsel1 = '0;
  logic [2:0]  rsel0 = '0, rsel1 = '0;

  logic        gnt0, gnt1, done0, done1, err0, err1;
  logic [31:0] rdata, mem_addr, mem_dataw;
  logic        mem_memrw;
  logic [1:0]  mem_wsel;
  logic [2:0]  mem_rsel;
  logic [31:0] mem_datar = '0;

  logic        f_gnt0, f_gnt1, f_done0, f_done1, f_err0, f_err1;
  logic [31:0] f_rdata, f_mem_addr, f_mem_dataw;
  logic        f_mem_memrw;
  logic [1:0]  f_mem_wsel;
  logic [2:0]  f_mem_rsel;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.DATA_WIDTH(32), .FIXED_PRIO(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .wsel0(wsel0), .rsel0(rsel0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .wsel1(wsel1), .rsel1(rsel1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err0(err0), .err1(err1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_dataw(mem_dataw),
    .mem_memrw(mem_memrw), .mem_wsel(mem_wsel),
    .mem_rsel(mem_rsel), .mem_datar(mem_datar)
  );

  dmem_arbiter #(.DATA_WIDTH(32), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .wsel0(wsel0), .rsel0(rsel0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .wsel1(wsel1), .rsel1(rsel1),
    .gnt0(f_gnt0), .gnt1(f_gnt1), .done0(f_done0), .done1(f_done1),
    .err0(f_err0), .err1(f_err1), .rdata(f_rdata),
    .mem_addr(f_mem_addr), .mem_dataw(f_mem_dataw),
    .mem_memrw(f_mem_memrw), .mem_wsel(f_mem_wsel),
    .mem_rsel(f_mem_rsel), .mem_datar(32'h0)
  );

  function automatic logic [31:0] ld_ext(
    input logic [31:0] w, input logic [2:0] rs);
    case (rs)
      3'b000:  return {{24{w[7]}}, w[7:0]};
      3'b010:  return {{16{w[15]}}, w[15:0]};
      3'b100:  return {24'h0, w[7:0]};
      3'b101:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] st_merge(
    input logic [31:0] old, input logic [31:0] d,
    input logic [1:0] ws);
    case (ws)
      2'b00:   return {old[31:8], d[7:0]};
      2'b01:   return {old[31:16], d[15:0]};
      default: return d;
    endcase
  endfunction

  // Data memory: write at the edge, read data registered.
  logic [31:0] bmem [1024];
  always @(posedge clk) begin
    if (mem_memrw)
      bmem[mem_addr[11:2]] <= st_merge(bmem[mem_addr[11:2]],
                                       mem_dataw, mem_wsel);
    mem_datar <= ld_ext(bmem[mem_addr[11:2]], mem_rsel);
  end

  // Transaction model: when free and a request is visible, the
  // access is scheduled as gnt at +1 and done at +2 (store/error)
  // or +3 (load); the arbiter is free again in the done cycle.
  typedef struct {
    bit          g0, g1, d0, d1, e0, e1, w, rdv;
    logic [31:0] rd, wa, wd;
    logic [1:0]  ws;
  } ev_t;

  ev_t         ev [64];
  logic [31:0] ref_mem [1024];
  int          cyc = 0;
  int          free_at = 0;
  bit          rr = 1'b0;
  logic [31:0] exp_rdata = '0;

  initial begin : cmp
    ev_t         e;
    bit          p, w, ill;
    logic [31:0] a, d;
    logic [1:0]  ws;
    logic [2:0]  rs;
    int          lat;
    logic [6:0]  act, exv;
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    for (int i = 0; i < 64; i++) ev[i] = '{default: '0};
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        vecs++;
        if ({gnt0, gnt1, done0, done1, err0, err1, mem_memrw} != 0
            || rdata != 0 || mem_addr != 0 || mem_dataw != 0
            || mem_wsel != 0 || mem_rsel != 0) begin
          errs++;
          $display("FAIL reset_outs cyc=%0d ctl=%b rdata=%h want 0",
                   cyc, {gnt0, gnt1, done0, done1, err0, err1,
                   mem_memrw}, rdata);
        end
        for (int i = 0; i < 64; i++) ev[i] = '{default: '0};
        rr = 1'b0;
        exp_rdata = '0;
        free_at = cyc + 1;
      end else begin
        e = ev[cyc % 64];
        ev[cyc % 64] = '{default: '0};
        if (e.w)
          ref_mem[e.wa[11:2]] = st_merge(ref_mem[e.wa[11:2]],
                                         e.wd, e.ws);
        if (e.rdv) exp_rdata = e.rd;
        act = {gnt0, gnt1, done0, done1, err0, err1, mem_memrw};
        exv = {e.g0, e.g1, e.d0, e.d1, e.e0, e.e1, e.w};
        vecs++;
        if (act !== exv) begin
          errs++;
          $display("FAIL ctl cyc=%0d g0g1d0d1e0e1rw got=%b want=%b",
                   cyc, act, exv);
        end
        vecs++;
        if (rdata !== exp_rdata) begin
          errs++;
          $display("FAIL rdata cyc=%0d got=%h want=%h",
                   cyc, rdata, exp_rdata);
        end
        if (cyc >= free_at && (req0 || req1)) begin
          p  = (req0 && req1) ? rr : req1;
          rr = !p;
          w  = p ? we1 : we0;
          a  = p ? addr1 : addr0;
          d  = p ? wdata1 : wdata0;
          ws = p ? wsel1 : wsel0;
          rs = p ? rsel1 : rsel0;
          ill = (a % 4 != 0) || (a >= 32'h0010_0000)
                || (w && ws == 2'b11)
                || (!w && (rs == 3'd1 || rs == 3'd6 || rs == 3'd7));
          lat = (ill || w) ? 2 : 3;
          if (p) ev[(cyc + 1) % 64].g1 = 1'b1;
          else   ev[(cyc + 1) % 64].g0 = 1'b1;
          if (p) ev[(cyc + lat) % 64].d1 = 1'b1;
          else   ev[(cyc + lat) % 64].d0 = 1'b1;
          if (ill) begin
            if (p) ev[(cyc + lat) % 64].e1 = 1'b1;
            else   ev[(cyc + lat) % 64].e0 = 1'b1;
          end else if (w) begin
            ev[(cyc + 1) % 64].w  = 1'b1;
            ev[(cyc + 1) % 64].wa = a;
            ev[(cyc + 1) % 64].wd = d;
            ev[(cyc + 1) % 64].ws = ws;
          end else begin
            ev[(cyc + lat) % 64].rdv = 1'b1;
            ev[(cyc + lat) % 64].rd  = ld_ext(ref_mem[a[11:2]], rs);
          end
          free_at = cyc + lat;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exv);
    vecs++;
    if (act !== exv) begin
      errs++;
      $display("FAIL %s got=%h want=%h", nm, act, exv);
    end
  endtask

  task automatic setp(input bit p, input bit w, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] ws,
                      input logic [2:0] rs);
    if (!p) begin
      we0 = w; addr0 = a; wdata0 = d; wsel0 = ws; rsel0 = rs;
      req0 = 1'b1;
    end else begin
      we1 = w; addr1 = a; wdata1 = d; wsel1 = ws; rsel1 = rs;
      req1 = 1'b1;
    end
  endtask

  // One access; checks gnt at +1, done at nd_exp and the err flag.
  task automatic acc(input string nm, input bit p, input bit w,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] ws, input logic [2:0] rs,
                     input int nd_exp, input bit err_exp);
    int ng, nd;
    ng = 0;
    nd = 0;
    setp(p, w, a, d, ws, rs);
    for (int i = 1; i <= 20 && ng == 0; i++) begin
      tick();
      if (p ? gnt1 : gnt0) ng = i;
    end
    if (p) req1 = 1'b0;
    else   req0 = 1'b0;
    chk({nm, "_gnt_lat"}, ng, 1);
    if (ng != 0) begin
      for (int i = ng + 1; i <= 20 && nd == 0; i++) begin
        tick();
        if (p ? done1 : done0) nd = i;
      end
    end
    chk({nm, "_done_lat"}, nd, nd_exp);
    chk({nm, "_err"}, p ? err1 : err0, err_exp);
  endtask

  task automatic settle_chk(input string nm, input logic [31:0] exv);
    @(negedge clk);
    #1;
    chk(nm, exp_rdata, exv);
    tick();
  endtask

  initial begin : drv
    int         n, ng, fg0, fg1, gcnt;
    logic [4:0] ord;
    logic [15:0] pos;
    repeat (3) tick();
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_ctl", {gnt0, gnt1, done0, done1, err0, err1, mem_memrw}, 0);
    rst_n = 1'b1;
    tick();

    acc("sw100", 0, 1, 32'h100, 32'hDEADBEEF, 2'b10, 3'b0, 2, 0);
    acc("lw100", 0, 0, 32'h100, 32'h0, 2'b0, 3'b011, 3, 0);
    chk("lw100_rdata", rdata, 32'hDEADBEEF);
    settle_chk("mdl_lw100", 32'hDEADBEEF);

    acc("sw200", 1, 1, 32'h200, 32'h11223344, 2'b10, 3'b0, 2, 0);
    acc("sb200", 1, 1, 32'h200, 32'h000000A5, 2'b00, 3'b0, 2, 0);
    acc("lbu200", 1, 0, 32'h200, 32'h0, 2'b0, 3'b100, 3, 0);
    chk("lbu200_rdata", rdata, 32'h000000A5);
    acc("sw204", 1, 1, 32'h204, 32'h00000080, 2'b10, 3'b0, 2, 0);
    acc("lb204", 1, 0, 32'h204, 32'h0, 2'b0, 3'b000, 3, 0);
    chk("lb204_rdata", rdata, 32'hFFFFFF80);
    settle_chk("mdl_lb204", 32'hFFFFFF80);
    acc("sw208", 0, 1, 32'h208, 32'h12348001, 2'b10, 3'b0, 2, 0);
    acc("lh208", 0, 0, 32'h208, 32'h0, 2'b0, 3'b010, 3, 0);
    chk("lh208_rdata", rdata, 32'hFFFF8001);
    acc("lhu208", 0, 0, 32'h208, 32'h0, 2'b0, 3'b101, 3, 0);
    chk("lhu208_rdata", rdata, 32'h00008001);

    acc("e_mis", 0, 1, 32'h102, 32'h55555555, 2'b10, 3'b0, 2, 1);
    acc("e_rng", 0, 0, 32'h0010_0000, 32'h0, 2'b0, 3'b011, 2, 1);
    acc("e_rs6", 0, 0, 32'h100, 32'h0, 2'b0, 3'b110, 2, 1);
    chk("err_rdata_hold", rdata, 32'h00008001);
    acc("lw100b", 0, 0, 32'h100, 32'h0, 2'b0, 3'b011, 3, 0);
    chk("lw100b_rdata", rdata, 32'hDEADBEEF);
    acc("e_ws3", 1, 1, 32'h100, 32'h0, 2'b11, 3'b0, 2, 1);
    chk("err_rdata_hold2", rdata, 32'hDEADBEEF);

    setp(0, 0, 32'h100, 32'h0, 2'b0, 3'b011);
    setp(1, 0, 32'h200, 32'h0, 2'b0, 3'b100);
    n = 0; ord = '0; fg0 = 0; fg1 = 0;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (gnt0 || gnt1) begin
        n++;
        ord = {ord[3:0], gnt1};
      end
      if (f_gnt0) fg0++;
      if (f_gnt1) fg1++;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    repeat (4) tick();
    chk("rr_count", n, 5);
    chk("rr_order", ord, 5'b01010);
    chk("fp_gnt1", fg1, 0);
    chk("fp_gnt0_ge3", (fg0 >= 3), 1);

    acc("sw300", 0, 1, 32'h300, 32'h01020304, 2'b10, 3'b0, 2, 0);
    setp(0, 1, 32'h300, 32'hFFFFFFFF, 2'b10, 3'b0);
    ng = 0;
    for (int i = 1; i <= 10 && ng == 0; i++) begin
      tick();
      if (gnt0) ng = i;
    end
    chk("rstacc_gnt_lat", ng, 1);
    chk("rstacc_memrw_pre", mem_memrw, 1);
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    chk("rstacc_memrw", mem_memrw, 0);
    chk("rstacc_ctl", {gnt0, gnt1, done0, done1, err0, err1}, 0);
    chk("rstacc_maddr", mem_addr, 32'h0);
    chk("rstacc_rdata", rdata, 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    acc("lw300", 0, 0, 32'h300, 32'h0, 2'b0, 3'b011, 3, 0);
    chk("lw300_rdata", rdata, 32'h01020304);

    setp(0, 0, 32'h100, 32'h0, 2'b0, 3'b011);
    gcnt = 0; pos = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (gnt0) begin
        gcnt++;
        pos[i] = 1'b1;
      end
    end
    req0 = 1'b0;
    repeat (4) tick();
    chk("b2b_count", gcnt, 4);
    chk("b2b_pos", pos, 16'h0492);
    chk("b2b_rdata", rdata, 32'hDEADBEEF);
    settle_chk("mdl_end", 32'hDEADBEEF);
    chk("fp_rdata", f_rdata, 32'h0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
